// File: rtl/tmr_pkg.sv
// tmr_pkg: shared replica count, fault vector type and the bitwise majority function.
package tmr_pkg;
    localparam int NREP = 3;
    typedef logic [NREP-1:0] fault_vec_t;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/tmr_voter.sv
// tmr_voter: combinational bitwise majority of three replicas plus mismatch and all-differ flags.
module tmr_voter
    import tmr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] v_o,
    output fault_vec_t       mis_o,
    output logic             all_diff_o
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_maj
        assign v_o[i] = maj3(a_i[i], b_i[i], c_i[i]);
    end
    assign mis_o      = {c_i != v_o, b_i != v_o, a_i != v_o};
    assign all_diff_o = (a_i != b_i) && (b_i != c_i) && (a_i != c_i);
endmodule

// File: rtl/tmr_updown_counter.sv
// tmr_updown_counter: TMR up/down modulo counter, scrubbed every cycle from the voted value.
// Define TMR_FAULT_CNT_EN to build the saturating per-replica fault event counters.
module tmr_updown_counter
    import tmr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter int               FCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_fcnt,
    output logic [WIDTH-1:0]  q,
    output logic              wrap,
    output fault_vec_t        fault,
    output logic              uncorrectable,
    output logic [FCNT_W-1:0] fcnt0,
    output logic [FCNT_W-1:0] fcnt1,
    output logic [FCNT_W-1:0] fcnt2
);
    // Replicas must survive synthesis as three distinct registers.
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] r0_q;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] r1_q;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] r2_q;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] n_d;
    fault_vec_t       mis;
    fault_vec_t       fault_q;
    logic             all_diff;
    logic             wrap_d;
    logic             wrap_q;
    logic             unc_q;

    tmr_voter #(.WIDTH(WIDTH)) u_voter (
        .a_i       (r0_q),
        .b_i       (r1_q),
        .c_i       (r2_q),
        .v_o       (v),
        .mis_o     (mis),
        .all_diff_o(all_diff)
    );

    always_comb begin
        n_d    = v;
        wrap_d = 1'b0;
        if (load) begin
            n_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en && up) begin
            n_d    = (v >= MAX_VAL) ? '0 : v + 1'b1;
            wrap_d = (v == MAX_VAL);
        end else if (en) begin
            n_d    = (v == '0 || v > MAX_VAL) ? MAX_VAL : v - 1'b1;
            wrap_d = (v == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            wrap_q  <= 1'b0;
            fault_q <= '0;
            unc_q   <= 1'b0;
        end else begin
            r0_q    <= n_d;
            r1_q    <= n_d;
            r2_q    <= n_d;
            wrap_q  <= wrap_d;
            fault_q <= mis;
            unc_q   <= all_diff;
        end
    end

    assign q             = v;
    assign wrap          = wrap_q;
    assign fault         = fault_q;
    assign uncorrectable = unc_q;

`ifdef TMR_FAULT_CNT_EN
    logic [NREP-1:0][FCNT_W-1:0] fcnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q <= '0;
        end else begin
            for (int i = 0; i < NREP; i++)
                if (clr_fcnt) fcnt_q[i] <= '0;
                else if (mis[i] && fcnt_q[i] != {FCNT_W{1'b1}}) fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
    end
    assign fcnt0 = fcnt_q[0];
    assign fcnt1 = fcnt_q[1];
    assign fcnt2 = fcnt_q[2];
`else
    logic unused_clr;
    assign unused_clr = clr_fcnt;
    assign fcnt0 = '0;
    assign fcnt1 = '0;
    assign fcnt2 = '0;
`endif
endmodule

// File: tb/tb_tmr_updown_counter.sv
// tb_tmr_updown_counter: scoreboard bench for the TMR counter (WIDTH=4, MAX_VAL=9, FCNT_W=8).
module tb_tmr_updown_counter;
    localparam logic [3:0] MX = 4'd9;
`ifdef TMR_FAULT_CNT_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif
    typedef struct packed {
        logic [3:0] q;
        logic       wrap;
        logic [2:0] fault;
        logic       unc;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic       clr_fcnt = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] q;
    logic       wrap;
    logic [2:0] fault;
    logic       uncorrectable;
    logic [7:0] fcnt0;
    logic [7:0] fcnt1;
    logic [7:0] fcnt2;

    exp_t       sb[$];
    logic [3:0] m0 = '0;
    logic [3:0] m1 = '0;
    logic [3:0] m2 = '0;
    logic [7:0] c[3] = '{default: '0};
    logic [3:0] i0;
    logic [3:0] i1;
    logic [3:0] i2;
    int         n_chk = 0;
    int         n_pass = 0;

    tmr_updown_counter #(.WIDTH(4), .MAX_VAL(MX), .FCNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .up           (up),
        .load         (load),
        .load_val     (load_val),
        .clr_fcnt     (clr_fcnt),
        .q            (q),
        .wrap         (wrap),
        .fault        (fault),
        .uncorrectable(uncorrectable),
        .fcnt0        (fcnt0),
        .fcnt1        (fcnt1),
        .fcnt2        (fcnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic [3:0] maj(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        return (a & b) | (a & d) | (b & d);
    endfunction

    task automatic check_outs(input exp_t x);
        chk("q", 32'(q), 32'(x.q));
        chk("wrap", 32'(wrap), 32'(x.wrap));
        chk("fault", 32'(fault), 32'(x.fault));
        chk("uncorrectable", 32'(uncorrectable), 32'(x.unc));
        chk("fcnt0", 32'(fcnt0), 32'(x.c0));
        chk("fcnt1", 32'(fcnt1), 32'(x.c1));
        chk("fcnt2", 32'(fcnt2), 32'(x.c2));
    endtask

    // Upset selected replicas for the remainder of the current cycle.
    task automatic inject(input logic [2:0] msk, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        i0 = a;
        i1 = b;
        i2 = d;
        if (msk[0]) begin force dut.r0_q = i0; m0 = a; end
        if (msk[1]) begin force dut.r1_q = i1; m1 = b; end
        if (msk[2]) begin force dut.r2_q = i2; m2 = d; end
        #1;
        chk("q_voted", 32'(q), 32'(maj(m0, m1, m2)));
        if (msk[0]) release dut.r0_q;
        if (msk[1]) release dut.r1_q;
        if (msk[2]) release dut.r2_q;
    endtask

    task automatic tick(input logic e, input logic u, input logic l, input logic [3:0] lv, input logic cl);
        exp_t       x;
        logic [3:0] v;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        clr_fcnt = cl;
        v        = maj(m0, m1, m2);
        x.fault  = {m2 != v, m1 != v, m0 != v};
        x.unc    = (m0 != m1) && (m1 != m2) && (m0 != m2);
        x.wrap   = 1'b0;
        if (l) x.q = (lv > MX) ? MX : lv;
        else if (e && u) begin x.q = (v >= MX) ? 4'd0 : v + 4'd1; x.wrap = (v == MX); end
        else if (e) begin x.q = (v == 4'd0 || v > MX) ? MX : v - 4'd1; x.wrap = (v == 4'd0); end
        else x.q = v;
        for (int k = 0; k < 3; k++)
            if (FC) c[k] = cl ? 8'd0 : (x.fault[k] && c[k] != 8'hFF) ? c[k] + 8'd1 : c[k];
        x.c0 = c[0];
        x.c1 = c[1];
        x.c2 = c[2];
        sb.push_back(x);
        m0 = x.q;
        m1 = x.q;
        m2 = x.q;
        @(posedge clk);
        #1;
        if (sb.size() == 0) chk("scoreboard_empty", 32'(1), 32'(0));
        else check_outs(sb.pop_front());
        @(negedge clk);
    endtask

    initial begin
        #3;
        check_outs('0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) tick(1, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0, 0);
        tick(1, 1, 1, 4'd9, 0);
        tick(1, 1, 1, 4'd12, 0);
        tick(1, 0, 1, 4'd5, 0);
        tick(0, 0, 0, 0, 0);
        inject(3'b010, 0, 4'd3, 0);
        tick(0, 0, 0, 0, 0);
        chk("r1_scrubbed", 32'(dut.r1_q), 32'(5));
        tick(0, 0, 0, 0, 0);
        inject(3'b111, 4'd1, 4'd2, 4'd4);
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        inject(3'b111, 4'd12, 4'd12, 4'd12);
        tick(1, 1, 0, 0, 0);
        inject(3'b111, 4'd12, 4'd12, 4'd12);
        tick(1, 0, 0, 0, 0);
        inject(3'b111, 4'd12, 4'd12, 4'd12);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            inject(3'b100, 0, 0, m0 ^ 4'd1);
            tick(0, 0, 0, 0, i == 299);
        end
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 4'd7, 0);
        inject(3'b001, 4'd2, 0, 0);
        tick(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        m0 = '0;
        m1 = '0;
        m2 = '0;
        c  = '{default: '0};
        check_outs('0);
        @(negedge clk);
        rst = 1'b0;
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
